// File: rtl/vga_tile_overlay.sv
// Tile-grid image overlay: grey image from ROM/RAM, a blinking border on the selected tile
// and a seven-segment label showing the selected tile number. Three-stage pixel pipeline.
module vga_tile_overlay #(
   parameter int H_ORG = 20,
   parameter int V_ORG = 40,
   parameter int TILE = 100,
   parameter int GRID = 4,
   parameter int BORDER = 1,
   parameter int BLINK_FRAMES = 30,
   parameter int LBL_X = 490,
   parameter int LBL_Y = 190,
   localparam int SELW = $clog2(GRID*GRID+1),
   localparam int ADDRW = $clog2((GRID*TILE)*(GRID*TILE))
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [9:0]       x,
   input  logic [9:0]       y,
   input  logic             frame_start,
   input  logic             start,
   input  logic             sel_valid,
   input  logic [SELW-1:0]  sel,
   output logic             sel_ready,
   output logic [ADDRW-1:0] drom_addr,
   input  logic [7:0]       drom_data,
   input  logic [31:0]      dram_data,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue
);

   localparam logic [9:0] IX0 = 10'(H_ORG);
   localparam logic [9:0] IX1 = 10'(H_ORG + GRID*TILE);
   localparam logic [9:0] IY0 = 10'(V_ORG);
   localparam logic [9:0] IY1 = 10'(V_ORG + GRID*TILE);
   localparam logic [9:0] LX0 = 10'(LBL_X);
   localparam logic [9:0] LX1 = 10'(LBL_X + 100);
   localparam logic [9:0] LY0 = 10'(LBL_Y);
   localparam logic [9:0] LY1 = 10'(LBL_Y + 100);
   localparam int CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNTW-1:0] CNT_MAX = (BLINK_FRAMES > 0) ? CNTW'(BLINK_FRAMES-1) : {CNTW{1'b0}};

   typedef enum logic [1:0] {CLS_OTHER, CLS_IMG, CLS_LBL} cls_t;

   cls_t            cls1, cls2;
   logic [9:0]      lx1, ly1;
   logic            border2, lit2;
   logic [SELW-1:0] active, pending, sel_clip, load_val;
   logic            load;
   logic [CNTW-1:0] cnt;
   logic            blink_phase;
   logic            in_img, in_lbl;
   logic [9:0]      tcol, trow, tx, ty, cx, cy;
   logic [SELW-1:0] tile_num;
   logic            on_edge, row_ok, in_tens, in_units, border_nxt, lit_nxt;
   logic [7:0]      val, tens8, units8, digit;
   logic            unused_dram;

   assign unused_dram = ^dram_data[31:8];

   // Segment bits are {g,f,e,d,c,b,a}; the one is drawn on the left strokes (f,e).
   function automatic logic [6:0] seven_seg(input logic [7:0] d);
      case (d)
         8'd0: seven_seg = 7'b0111111;
         8'd1: seven_seg = 7'b0110000;
         8'd2: seven_seg = 7'b1011011;
         8'd3: seven_seg = 7'b1001111;
         8'd4: seven_seg = 7'b1100110;
         8'd5: seven_seg = 7'b1101101;
         8'd6: seven_seg = 7'b1111101;
         8'd7: seven_seg = 7'b0000111;
         8'd8: seven_seg = 7'b1111111;
         8'd9: seven_seg = 7'b1101111;
         default: seven_seg = 7'b0000000;
      endcase
   endfunction

   function automatic logic seg_hit(input logic [6:0] s, input logic [9:0] px, input logic [9:0] py);
      seg_hit = (s[0] && py < 10'd10)
             || (s[6] && py >= 10'd35 && py <= 10'd44)
             || (s[3] && py >= 10'd70 && py <= 10'd79)
             || (s[5] && px < 10'd10 && py <= 10'd44)
             || (s[1] && px >= 10'd20 && py <= 10'd44)
             || (s[4] && px < 10'd10 && py >= 10'd35)
             || (s[2] && px >= 10'd20 && py >= 10'd35);
   endfunction

   assign in_img = (x >= IX0) && (x < IX1) && (y >= IY0) && (y < IY1);
   assign in_lbl = (x >= LX0) && (x < LX1) && (y >= LY0) && (y < LY1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drom_addr <= '0;
         cls1      <= CLS_OTHER;
         lx1       <= '0;
         ly1       <= '0;
      end else if (in_img) begin
         cls1      <= CLS_IMG;
         lx1       <= x - IX0;
         ly1       <= y - IY0;
         drom_addr <= ADDRW'(y - IY0) * ADDRW'(GRID*TILE) + ADDRW'(x - IX0);
      end else if (in_lbl) begin
         cls1 <= CLS_LBL;
         lx1  <= x - LX0;
         ly1  <= y - LY0;
      end else begin
         cls1 <= CLS_OTHER;
      end
   end

   // A request arriving with frame_start goes straight to active and never blocks the port.
   assign sel_clip = (sel > SELW'(GRID*GRID)) ? '0 : sel;
   assign load_val = (sel_valid && sel_ready) ? sel_clip : pending;
   assign load     = frame_start && ((sel_valid && sel_ready) || !sel_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active      <= '0;
         pending     <= '0;
         sel_ready   <= 1'b1;
         cnt         <= '0;
         blink_phase <= 1'b1;
      end else begin
         if (sel_valid && sel_ready && !frame_start) begin
            pending   <= sel_clip;
            sel_ready <= 1'b0;
         end else if (frame_start && !sel_ready) begin
            pending   <= '0;
            sel_ready <= 1'b1;
         end
         if (load)
            active <= load_val;
         if (load && (load_val != active)) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
         end else if (frame_start) begin
            if (BLINK_FRAMES == 0) begin
               blink_phase <= 1'b1;
            end else if (cnt == CNT_MAX) begin
               cnt         <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               cnt <= cnt + CNTW'(1);
            end
         end
      end
   end

   always_comb begin
      tcol       = lx1 / 10'(TILE);
      trow       = ly1 / 10'(TILE);
      tx         = lx1 % 10'(TILE);
      ty         = ly1 % 10'(TILE);
      tile_num   = SELW'(trow * 10'(GRID) + tcol + 10'd1);
      on_edge    = (tx < 10'(BORDER)) || (ty < 10'(BORDER))
                || (tx >= 10'(TILE-BORDER)) || (ty >= 10'(TILE-BORDER));
      border_nxt = (active != '0) && (tile_num == active) && on_edge && blink_phase;

      val      = 8'(active);
      tens8    = val / 8'd10;
      units8   = val % 8'd10;
      row_ok   = (ly1 >= 10'd10) && (ly1 <= 10'd89);
      in_tens  = (lx1 >= 10'd10) && (lx1 <= 10'd39);
      in_units = (lx1 >= 10'd50) && (lx1 <= 10'd79);
      cy       = ly1 - 10'd10;
      cx       = in_tens ? (lx1 - 10'd10) : (lx1 - 10'd50);
      digit    = in_tens ? tens8 : units8;
      lit_nxt  = (active != '0) && row_ok && (in_units || (in_tens && tens8 != 8'd0))
              && seg_hit(seven_seg(digit), cx, cy);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cls2    <= CLS_OTHER;
         border2 <= 1'b0;
         lit2    <= 1'b0;
      end else begin
         cls2    <= cls1;
         border2 <= border_nxt;
         lit2    <= lit_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {red, green, blue} <= '0;
      end else begin
         case (cls2)
            CLS_IMG: begin
               if (start)
                  {red, green, blue} <= {3{dram_data[7:0]}};
               else if (border2)
                  {red, green, blue} <= 24'hFF0000;
               else
                  {red, green, blue} <= {3{drom_data}};
            end
            CLS_LBL: {red, green, blue} <= lit2 ? 24'hFF0000 : 24'h000000;
            default: {red, green, blue} <= '0;
         endcase
      end
   end

endmodule
